// File: rtl/cim_pkg.sv
// cim_pkg: shared FSM state type and default geometry for the CIM row accumulator.
package cim_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int WIDTH_D = 8;
  localparam int ROWS_D  = 16;
  localparam int ACC_W_D = 16;
endpackage

// File: rtl/cim_sat_add.sv
// cim_sat_add: combinational unsigned adder that clamps to all-ones and flags overflow.
module cim_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    ovf = sum[W];
    y   = ovf ? {W{1'b1}} : sum[W-1:0];
  end
endmodule

// File: rtl/cim_row_accumulator.sv
// cim_row_accumulator: sums ROWS bitcell-chain row results into a saturating total with valid/ready output.
// Optional threshold compare for the BNN activation bit is enabled by defining CIM_THRESHOLD_EN.
module cim_row_accumulator
  import cim_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int ROWS  = ROWS_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             row_valid,
  input  logic [WIDTH-1:0] row_sum,
  input  logic             row_co,
  output logic             row_ready,
  input  logic [ACC_W-1:0] threshold,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             act_out,
  output logic             sat,
  output logic             busy
);
  localparam int CNT_W = $clog2(ROWS + 1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] row_val, sum_y;
  logic ovf, accept, last;
  assign row_val   = ACC_W'({row_co, row_sum});
  assign row_ready = state == ACCUM;
  assign busy      = state != IDLE;
  assign accept    = row_ready & row_valid;
  assign last      = accept & (cnt == CNT_W'(ROWS - 1));
  cim_sat_add #(.W(ACC_W)) u_add (
    .a  (acc_out),
    .b  (row_val),
    .y  (sum_y),
    .ovf(ovf)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ACCUM : IDLE;
      ACCUM:   nxt = last ? DONE : ACCUM;
      DONE:    nxt = acc_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      state     <= nxt;
      acc_valid <= nxt == DONE;
      if (state == IDLE && start) begin
        acc_out <= '0;
        cnt     <= '0;
        sat     <= 1'b0;
      end else if (accept) begin
        acc_out <= sum_y;
        cnt     <= cnt + CNT_W'(1);
        sat     <= sat | ovf;
      end
    end
  end
`ifdef CIM_THRESHOLD_EN
  // compare the post-add total so the bit is ready alongside acc_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) act_out <= 1'b0;
    else if (state == IDLE && start) act_out <= 1'b0;
    else if (last) act_out <= sum_y >= threshold;
  end
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign act_out = 1'b0;
`endif
endmodule

// File: tb/tb_cim_row_accumulator.sv
// tb_cim_row_accumulator: scoreboard bench; one 12-bit and one 10-bit accumulator share stimulus.
module tb_cim_row_accumulator;
`ifdef CIM_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif
  typedef struct {logic [11:0] acc; logic sat; logic act;} exp_t;
  logic clk = 0, rst = 1, start = 0, row_valid = 0, row_co = 0, acc_ready = 0;
  logic [7:0] row_sum = '0;
  logic [11:0] thr_a = 12'd20, a_acc;
  logic [9:0] thr_b = 10'd20, b_acc;
  logic a_rr, a_valid, a_act, a_sat, a_busy;
  logic b_rr, b_valid, b_act, b_sat, b_busy;
  int n_chk = 0, n_pass = 0;
  exp_t q_a[$], q_b[$];
  always #5 clk = ~clk;
  cim_row_accumulator #(.WIDTH(8), .ROWS(4), .ACC_W(12)) dut_a (
    .clk(clk), .rst(rst), .start(start), .row_valid(row_valid), .row_sum(row_sum),
    .row_co(row_co), .row_ready(a_rr), .threshold(thr_a), .acc_valid(a_valid),
    .acc_ready(acc_ready), .acc_out(a_acc), .act_out(a_act), .sat(a_sat), .busy(a_busy));
  cim_row_accumulator #(.WIDTH(8), .ROWS(4), .ACC_W(10)) dut_b (
    .clk(clk), .rst(rst), .start(start), .row_valid(row_valid), .row_sum(row_sum),
    .row_co(row_co), .row_ready(b_rr), .threshold(thr_b), .acc_valid(b_valid),
    .acc_ready(acc_ready), .acc_out(b_acc), .act_out(b_act), .sat(b_sat), .busy(b_busy));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  always @(negedge clk) begin
    if (!rst && a_valid) begin
      if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        chk("a_acc", a_acc, q_a[0].acc);
        chk("a_sat", a_sat, q_a[0].sat);
        chk("a_act", a_act, q_a[0].act);
        if (acc_ready) void'(q_a.pop_front());
      end
    end
    if (!rst && b_valid) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        chk("b_acc", b_acc, q_b[0].acc);
        chk("b_sat", b_sat, q_b[0].sat);
        chk("b_act", b_act, q_b[0].act);
        if (acc_ready) void'(q_b.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_dot(input logic [3:0][8:0] v, input bit gaps, input int hold,
                         input logic [11:0] ea, input logic sa, input logic ga,
                         input logic [11:0] eb, input logic sb, input logic gb);
    exp_t e;
    e.acc = ea; e.sat = sa; e.act = THR_EN & ga; q_a.push_back(e);
    e.acc = eb; e.sat = sb; e.act = THR_EN & gb; q_b.push_back(e);
    if (gaps) begin
      row_valid = 1; {row_co, row_sum} = 9'h1AA;
      tick();
      row_valid = 0;
    end
    start = 1;
    tick();
    start = 0;
    chk("row_ready_after_start", {a_rr, b_rr}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      row_valid = 1; {row_co, row_sum} = v[i];
      tick();
      if (gaps && i < 3) begin
        row_valid = 0; {row_co, row_sum} = 9'($urandom);
        tick();
      end
    end
    row_valid = 0;
    chk("acc_valid_latency", {a_valid, b_valid}, 2'b11);
    for (int h = 0; h < hold; h++) begin
      start = h == 1;
      tick();
    end
    acc_ready = 1; start = hold > 0;
    tick();
    acc_ready = 0; start = 0;
    chk("idle_after_handshake", {a_busy, b_busy, a_valid, b_valid}, 4'b0);
  endtask
  initial begin
    #2;
    chk("reset_outputs_a", {a_acc, a_act, a_sat, a_rr, a_valid, a_busy}, '0);
    chk("reset_outputs_b", {b_acc, b_act, b_sat, b_rr, b_valid, b_busy}, '0);
    tick(); tick();
    rst = 0;
    tick();
    run_dot({9'd5, 9'd5, 9'd5, 9'd5}, 0, 0, 12'h014, 0, 1, 12'h014, 0, 1);
    run_dot({9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, 0, 0, 12'h7FC, 0, 1, 12'h3FF, 1, 1);
    run_dot({9'd4, 9'd3, 9'd2, 9'd1}, 1, 0, 12'd10, 0, 0, 12'd10, 0, 0);
    run_dot({9'd4, 9'd5, 9'd5, 9'd5}, 0, 3, 12'd19, 0, 0, 12'd19, 0, 0);
    run_dot({9'd1, 9'h1FF, 9'h1FF, 9'h1FF}, 0, 0, 12'd1534, 0, 1, 12'h3FF, 1, 1);
    run_dot({9'd1, 9'd1, 9'd1, 9'd1}, 0, 0, 12'd4, 0, 0, 12'd4, 0, 0);
    start = 1;
    tick();
    start = 0; row_valid = 1; {row_co, row_sum} = 9'd9;
    tick();
    tick();
    row_valid = 0;
    chk("partial_sum_before_reset", {a_acc, b_acc}, {12'd18, 10'd18});
    #2 rst = 1;
    #1;
    chk("async_reset_a", {a_acc, a_act, a_sat, a_rr, a_valid, a_busy}, '0);
    chk("async_reset_b", {b_acc, b_act, b_sat, b_rr, b_valid, b_busy}, '0);
    tick();
    rst = 0;
    tick();
    run_dot({9'd1, 9'd0, 9'd0, 9'd7}, 0, 0, 12'd8, 0, 0, 12'd8, 0, 0);
    tick(); tick();
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cim_row_accumulator.md
# cim_row_accumulator

Downstream consumer of a compute-in-memory bitcell row chain. Each cycle the chain presents one row's XNOR/full-adder result as a WIDTH-bit sum vector plus the final ripple carry. This block accepts ROWS such row results per dot-product, accumulates them into a saturating ACC_W-bit total and hands the total to the next stage through a valid/ready handshake. An optional binary-activation threshold compare produces the sign bit for BNN layers.

## Interface
- WIDTH, 8: bit width of the row sum vector from the bitcell chain
- ROWS, 16: row results per dot-product, ≥1
- ACC_W, 16: accumulator width, ≥ WIDTH+1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a new dot-product; honoured only in IDLE
- row_valid  in  1  row result present
- row_sum  in  WIDTH  row sum bits (chain OUTPUT bits, LSB = column 0)
- row_co  in  1  final carry-out of the chain
- row_ready  out  1  block accepts a row this cycle
- threshold  in  ACC_W  activation threshold, unsigned
- acc_valid  out  1  result available
- acc_ready  in  1  downstream accepts result
- acc_out  out  ACC_W  accumulated total
- act_out  out  1  activation bit (acc_out ≥ threshold)
- sat  out  1  saturation occurred during this dot-product
- busy  out  1  state ≠ IDLE

## Operation
- Row value = {row_co, row_sum}, unsigned WIDTH+1 bits, zero-extended to ACC_W+1 before adding.
- FSM states IDLE, ACCUM, DONE.
- IDLE: row_ready=0, acc_valid=0. On start: acc←0, cnt←0, sat←0, go ACCUM.
- ACCUM: row_ready=1. On row_valid&row_ready: acc←sat_add(acc, row value), cnt←cnt+1. When the accepted row is row ROWS-1, go DONE. row_valid low: hold, no change.
- sat_add: if sum > 2^ACC_W−1, result = 2^ACC_W−1 and sat←1. sat stays set (sticky) until the next start.
- DONE: acc_valid=1. acc_out, act_out and sat stay stable until acc_valid&acc_ready, then go IDLE.
- start outside IDLE is ignored. start in the same cycle as the DONE→IDLE handshake is also ignored and must be reissued.
- Row inputs are ignored outside ACCUM.
- cnt width is clog2(ROWS+1). ROWS=1 goes ACCUM→DONE on the first accepted row.

## Timing
- Reset values: state=IDLE, acc_out=0, act_out=0, sat=0, row_ready=0, acc_valid=0, busy=0.
- Asynchronous reset mid-operation discards the partial sum immediately. It does not wait for the next clock edge.
- start → row_ready high: 1 cycle.
- Last row accepted → acc_valid high: the next cycle, i.e. registered, 1-cycle latency.
- Minimum dot-product duration: 1 (start) + ROWS + 1 (handshake) cycles.
- All outputs are registered except row_ready and busy, which are decoded from state.

## Configuration
- CIM_THRESHOLD_EN defined:
  - act_out is registered as (final acc ≥ threshold).
  - threshold is sampled on the cycle the last row is accepted.
- CIM_THRESHOLD_EN undefined:
  - no compare logic; act_out is tied to 0.
  - the threshold port exists but is ignored.

## Structure
- Shared package cim_pkg holds:
  - state enum (IDLE, ACCUM, DONE)
  - default WIDTH, ROWS and ACC_W constants
- One sub-module, cim_sat_add: combinational saturating adder, ACC_W wide, with an overflow flag.
- The FSM, counter and output registers live in the top module.

## Test plan
- WIDTH=8, ROWS=4, ACC_W=12; start, then four rows of row_sum=0x05, row_co=0 → acc_out=0x014, sat=0, acc_valid one cycle after the 4th accept.
- Same config; four rows of row_sum=0xFF, row_co=1 (511 each) → acc_out=2044 (0x7FC), sat=0. Repeat with ACC_W=10 → acc_out=0x3FF, sat=1.
- row_valid toggled 1,0,1,0,… with values 1,2,3,4 → acc_out=10; idle cycles do not advance cnt.
- acc_ready held low 3 cycles in DONE → acc_valid and acc_out stable; start pulsed during DONE is ignored; IDLE after the handshake.
- rst asserted after 2 of 4 rows → all outputs read reset values in the same cycle. A new start then sums only the new rows.
- CIM_THRESHOLD_EN defined, threshold=20:
  - rows summing to 20 → act_out=1
  - rows summing to 19 → act_out=0
  - macro undefined → act_out=0 always
